// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - program store and issue sequencer feeding the register-file processor
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   load_en/addr/data     write one 34-bit instruction into a program slot (dropped while busy)
//   prog_len, start       number of instructions to run and the launch pulse (ignored while busy)
//   op_done, res1, res2   processor completion flag and its two read outputs
//   instruct, instruct_sig  instruction word and its valid flag (low = prepare cycle)
//   pc, busy, prog_done   issued slot, run-in-progress flag, end-of-program pulse
//   timeout_err           sticky watchdog flag, cleared by an accepted start
//   last_res1, last_res2  processor results captured at the latest completion
module instruction_sequencer #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [33:0]   load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          op_done,
    input  logic [15:0]   res1,
    input  logic [15:0]   res2,
    output logic [33:0]   instruct,
    output logic          instruct_sig,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          prog_done,
    output logic          timeout_err,
    output logic [15:0]   last_res1,
    output logic [15:0]   last_res2
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_ISSUE,
        S_NEXT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [33:0]     mem [DEPTH];
    logic [AW:0]     len;
    logic [CW-1:0]   wait_cnt;
    logic [AW-1:0]   pc_inc;
    logic            pc_last;

    logic            accept_start;
    logic            zero_start;
    logic            complete;
    logic            expire;
    logic            finish;
    logic            advance;

    assign pc_inc  = pc + AW'(1);
    // len is one bit wider than pc so that a full-depth program never wraps
    assign pc_last = ({1'b0, pc} == (len - (AW+1)'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        busy         = 1'b1;
        instruct_sig = 1'b0;
        accept_start = 1'b0;
        zero_start   = 1'b0;
        complete     = 1'b0;
        expire       = 1'b0;
        finish       = 1'b0;
        advance      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (prog_len == '0) begin
                        zero_start = 1'b1;
                    end else begin
                        accept_start = 1'b1;
                        state_next   = S_PREP;
                    end
                end
            end
            S_PREP: begin
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                instruct_sig = 1'b1;
                // completion is tested first so it wins on the final watchdog cycle
                if (op_done) begin
                    complete   = 1'b1;
                    state_next = S_NEXT;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    expire     = 1'b1;
                    state_next = S_NEXT;
                end
            end
            S_NEXT: begin
                if (pc_last) begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    advance    = 1'b1;
                    state_next = S_PREP;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Program store is deliberately left out of reset so a run can be repeated after rst
    always_ff @(posedge clk) begin
        if (load_en && (state == S_IDLE)) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instruct    <= '0;
            pc          <= '0;
            len         <= '0;
            wait_cnt    <= '0;
            prog_done   <= 1'b0;
            timeout_err <= 1'b0;
            last_res1   <= '0;
            last_res2   <= '0;
        end else begin
            prog_done <= zero_start | finish;
            if (accept_start || zero_start) begin
                timeout_err <= 1'b0;
            end
            // instruct is loaded on the edge into PREP so it is stable for the whole PREP/ISSUE span
            if (accept_start) begin
                len      <= prog_len;
                pc       <= '0;
                instruct <= mem[0];
            end
            if (advance) begin
                pc       <= pc_inc;
                instruct <= mem[pc_inc];
            end
            if (state == S_PREP) begin
                wait_cnt <= '0;
            end else if (state == S_ISSUE) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (complete) begin
                last_res1 <= res1;
                last_res2 <= res2;
            end
            if (expire) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - self-checking bench for instruction_sequencer
module tb_instruction_sequencer;

    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int TIMEOUT = 32;
    localparam int NEVER   = 999;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [33:0]   load_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          op_done;
    logic [15:0]   res1;
    logic [15:0]   res2;
    logic [33:0]   instruct;
    logic          instruct_sig;
    logic [AW-1:0] pc;
    logic          busy;
    logic          prog_done;
    logic          timeout_err;
    logic [15:0]   last_res1;
    logic [15:0]   last_res2;

    instruction_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .prog_len(prog_len), .start(start),
        .op_done(op_done), .res1(res1), .res2(res2),
        .instruct(instruct), .instruct_sig(instruct_sig), .pc(pc),
        .busy(busy), .prog_done(prog_done), .timeout_err(timeout_err),
        .last_res1(last_res1), .last_res2(last_res2)
    );

    always #5 clk = ~clk;

    // Behavioural model: expected output values for the current cycle
    logic [33:0]   model_mem [DEPTH];
    logic [33:0]   m_instr;
    logic [AW-1:0] m_pc;
    logic          m_busy, m_sig, m_done, m_done_pend, m_terr;
    logic [15:0]   m_r1, m_r2;

    int  lat_tab [DEPTH];
    bit  force_res;
    bit  disturb;
    int  abort_k;
    bit  chk_en;
    int  cyc;
    int  n_checks;
    int  n_pass;
    int  cnt_sig, cnt_busy, cnt_done;

    task automatic check(input string nm, input logic [33:0] act, input logic [33:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("instruct", instruct, m_instr);
            check("instruct_sig", 34'(instruct_sig), 34'(m_sig));
            check("pc", 34'(pc), 34'(m_pc));
            check("busy", 34'(busy), 34'(m_busy));
            check("prog_done", 34'(prog_done), 34'(m_done));
            check("timeout_err", 34'(timeout_err), 34'(m_terr));
            check("last_res1", 34'(last_res1), 34'(m_r1));
            check("last_res2", 34'(last_res2), 34'(m_r2));
            cnt_sig  += int'(instruct_sig);
            cnt_busy += int'(busy);
            cnt_done += int'(prog_done);
        end
    end

    task automatic model_reset();
        m_instr = '0; m_pc = '0; m_busy = 0; m_sig = 0;
        m_done = 0; m_done_pend = 0; m_terr = 0; m_r1 = '0; m_r2 = '0;
    endtask

    task automatic clr_cnt();
        cnt_sig = 0; cnt_busy = 0; cnt_done = 0;
    endtask

    // Enter the next cycle with idle inputs and a deterministic result pattern
    task automatic step();
        @(posedge clk); #1;
        cyc++;
        rst = 0; load_en = 0; start = 0; op_done = 0;
        res1 = 16'(cyc * 311);
        res2 = 16'(cyc * 11269) ^ 16'h5a5a;
        m_done = m_done_pend;
        m_done_pend = 0;
    endtask

    // Loads only land in the program store while the sequencer is idle
    task automatic drive_load(input int a, input logic [33:0] d);
        load_en = 1; load_addr = AW'(a); load_data = d;
        if (!m_busy) model_mem[a] = d;
    endtask

    // Run n instructions; lat_tab[k] = cycles after ISSUE entry that op_done pulses
    task automatic run(input int n);
        int c;
        bit ok;
        logic [15:0] c1, c2;
        step();
        start = 1; prog_len = (AW+1)'(n);
        if (n == 0) begin
            m_done_pend = 1;
            step();
            step();
            return;
        end
        for (int k = 0; k < n; k++) begin
            step();
            m_busy = 1; m_sig = 0; m_pc = AW'(k); m_instr = model_mem[k];
            if (k == 0) m_terr = 0;
            ok = 0; c = 0; c1 = '0; c2 = '0;
            forever begin
                step();
                m_sig = 1;
                if (disturb && k == 0 && c == 0) begin
                    start = 1; prog_len = (AW+1)'(1);
                    drive_load(0, 34'h3_dead_beef);
                end
                if (k == abort_k && c == 1) begin
                    rst = 1;
                    step();
                    model_reset();
                    return;
                end
                if (c == lat_tab[k]) begin
                    op_done = 1;
                    if (force_res) begin res1 = 16'haaaa; res2 = 16'h5555; end
                    c1 = res1; c2 = res2; ok = 1;
                    break;
                end
                if (c == TIMEOUT - 1) break;
                c++;
            end
            step();
            m_sig = 0;
            if (ok) begin m_r1 = c1; m_r2 = c2; end
            else m_terr = 1;
            if (k == n - 1) m_done_pend = 1;
        end
        step();
        m_busy = 0;
        step();
    endtask

    task automatic set_lat(input int v);
        for (int i = 0; i < DEPTH; i++) lat_tab[i] = v;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; chk_en = 0;
        force_res = 0; disturb = 0; abort_k = -1;
        load_en = 0; load_addr = '0; load_data = '0; prog_len = '0;
        start = 0; op_done = 0; res1 = '0; res2 = '0;
        model_reset();
        clr_cnt();
        set_lat(0);
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        step();
        chk_en = 1;

        // fill the program store
        for (int i = 0; i < DEPTH; i++) begin
            step();
            if (i == 0)      drive_load(i, {3'b000, 15'd0, 16'h1234});
            else if (i == 1) drive_load(i, {3'b001, 15'd0, 16'h0042});
            else             drive_load(i, {3'(i), 15'(i * 3), 16'(i * 4369)});
        end
        step();

        // two instructions, op_done three cycles after each ISSUE entry
        clr_cnt(); set_lat(3);
        run(2);
        lit("t1_done_pulses", cnt_done, 1);
        lit("t1_sig_cycles", cnt_sig, 8);
        lit("t1_busy_cycles", cnt_busy, 12);
        lit("t1_pc_final", int'(pc), 1);

        // result capture with fixed values
        force_res = 1; set_lat(5);
        run(1);
        force_res = 0;
        lit("t2_last_res1", int'(last_res1), 16'haaaa);
        lit("t2_last_res2", int'(last_res2), 16'h5555);

        // zero-length program
        clr_cnt();
        run(0);
        lit("t3_busy_cycles", cnt_busy, 0);
        lit("t3_done_pulses", cnt_done, 1);

        // watchdog expiry
        clr_cnt(); set_lat(NEVER);
        run(1);
        lit("t4_timeout_err", int'(timeout_err), 1);
        lit("t4_sig_cycles", cnt_sig, TIMEOUT);
        lit("t4_done_pulses", cnt_done, 1);
        lit("t4_res1_held", int'(last_res1), 16'haaaa);

        // completion on the last watchdog cycle wins
        clr_cnt(); set_lat(TIMEOUT - 1); force_res = 1;
        run(1);
        force_res = 0;
        lit("t5_timeout_err", int'(timeout_err), 0);
        lit("t5_sig_cycles", cnt_sig, TIMEOUT);
        lit("t5_last_res2", int'(last_res2), 16'h5555);

        // start and load while busy are dropped; rerun shows slot 0 intact
        clr_cnt(); set_lat(2); disturb = 1;
        run(2);
        disturb = 0;
        lit("t6_done_pulses", cnt_done, 1);
        lit("t6_pc_final", int'(pc), 1);
        run(1);

        // reset during ISSUE of slot 2 of 4, then rerun
        clr_cnt(); set_lat(1); abort_k = 2;
        run(4);
        abort_k = -1;
        step();
        lit("t7_no_done", cnt_done, 0);
        lit("t7_pc_reset", int'(pc), 0);
        clr_cnt();
        for (int i = 0; i < 4; i++) lat_tab[i] = i;
        run(4);
        lit("t7_rerun_done", cnt_done, 1);

        // full-depth program stops at the last slot
        clr_cnt(); set_lat(0);
        run(DEPTH);
        lit("t8_sig_cycles", cnt_sig, DEPTH);
        lit("t8_busy_cycles", cnt_busy, 3 * DEPTH);
        lit("t8_pc_final", int'(pc), DEPTH - 1);

        step();
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Upstream stage of the register-file processor.
- Holds a small program of 34-bit instructions loaded by the testbench or host. On start, it issues the instructions one at a time over the processor's instruct/instruct_sig handshake.
- Waits for the processor's completion flag, or a watchdog timeout, before advancing. Captures the processor's read outputs for each instruction.

Parameters:
- DEPTH, 16, number of program slots (power of two, 2..32)
- AW, 4, program address width, equal to log2(DEPTH)
- TIMEOUT, 32, maximum cycles to wait for completion before forcing advance (must be > 21)

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  synchronous, active-high reset
- load_en  in  1  write load_data into program slot load_addr this cycle (ignored while busy)
- load_addr  in  AW  program slot for load
- load_data  in  34  instruction word; [33:31] opcode, [15:0] immediate
- prog_len  in  AW+1  number of instructions to run (0..DEPTH), sampled on start
- start  in  1  one-cycle pulse; begins execution at slot 0 (ignored while busy)
- op_done  in  1  processor completion flag (output_sig), sampled at rising edge
- res1  in  16  processor out1
- res2  in  16  processor out2
- instruct  out  34  instruction presented to the processor
- instruct_sig  out  1  0 = prepare cycle, 1 = instruction valid
- pc  out  AW  slot currently issued
- busy  out  1  high from start acceptance until return to IDLE
- prog_done  out  1  one-cycle pulse when the last instruction completes
- timeout_err  out  1  sticky; set when any instruction times out, cleared by start or rst
- last_res1  out  16  res1 captured on completion of the most recent instruction
- last_res2  out  16  res2 captured likewise

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; instruct=0, instruct_sig=0, pc=0, busy=0, prog_done=0, timeout_err=0, last_res1=0, last_res2=0.
  - Wait counter cleared. Program memory contents are not cleared.
  - rst mid-run aborts immediately; there is no prog_done pulse.
- Program memory: DEPTH x 34 registers, written synchronously when load_en=1 and busy=0. Loads while busy are dropped.
- Unused instruct fields are passed through unmodified; this block does not decode.
- State machine:
  - IDLE: busy=0, instruct_sig=0.
    - start=1 and prog_len=0: stay IDLE, pulse prog_done next cycle, never assert busy.
    - start=1 and prog_len>0: latch length, pc=0, clear timeout_err, go PREP.
  - PREP (exactly 1 cycle): busy=1, instruct_sig=0, instruct=mem[pc], wait counter=0. Go ISSUE.
  - ISSUE: instruct_sig=1; instruct holds mem[pc] stable. Wait counter increments each cycle.
    - op_done=1: capture res1/res2 into last_res1/last_res2 on the same edge, go NEXT.
    - Otherwise, counter reaches TIMEOUT-1: set timeout_err, leave last_res unchanged, go NEXT.
    - op_done and timeout in the same cycle: completion wins; no error is set.
  - NEXT (1 cycle): instruct_sig=0.
    - pc == length-1: pulse prog_done, busy falls, go IDLE, pc retained.
    - Otherwise: pc=pc+1, go PREP.
- start while busy is ignored; there is no restart mid-run.
- The pc arithmetic never wraps: prog_len=DEPTH runs slots 0..DEPTH-1 and then stops.
- Minimum per-instruction issue cost is 3 cycles (PREP, ISSUE, NEXT) plus the processor's latency.
- Ordering: instruct_sig is always low for at least one full cycle between consecutive instructions, so the processor re-arms.

Test Plan:
- Load slot0=opcode 000 imm 0x1234, slot1=opcode 001; prog_len=2, start; op_done pulse 3 cycles after each ISSUE entry -> two PREP/ISSUE sequences with instruct_sig low 1 cycle each; pc 0 then 1; prog_done pulses once; busy low after.
- Single instruction, op_done held low -> timeout_err=1 after TIMEOUT cycles in ISSUE; prog_done still pulses; last_res1/2 unchanged.
- op_done with res1=0xAAAA, res2=0x5555 -> last_res1=0xAAAA, last_res2=0x5555 on the completion edge.
- prog_len=0 start -> busy stays 0, prog_done pulses one cycle later. Start while busy and load while busy -> no effect (verify mem and pc).
- rst asserted during ISSUE of slot 2 of 4 -> next cycle all outputs at reset values, no prog_done; a subsequent start reruns from slot 0 with the program intact.
- op_done asserted on the exact TIMEOUT-1 cycle -> timeout_err stays 0; results captured.
